queue_writer: RTL and testbench

//  Producer-side controller for the 4-entry nibble queue (enq/deq/din/dout, enq wins over deq).

---
 rtl/queue_pkg.sv | 21 ++
 rtl/queue_writer_skid.sv | 68 ++++++
 rtl/queue_writer.sv | 169 ++++++++++++++++
 tb/tb_queue_writer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/queue_pkg.sv
// Shared definitions for the nibble-queue producer side.
//  - Q_DW / Q_DEPTH / Q_MAX_YIELD : default data width, queue depth, fairness yield limit
//  - writer_state_e               : writer FSM encoding (IDLE / ACTIVE / BLOCKED)
//  - occ_w()                      : bit width needed to hold an occupancy of 0..depth
package queue_pkg;

    localparam int Q_DW        = 4;
    localparam int Q_DEPTH     = 4;
    localparam int Q_MAX_YIELD = 4;

    typedef enum logic [1:0] {
        WR_IDLE    = 2'd0,   // skid buffer empty
        WR_ACTIVE  = 2'd1,   // data buffered and the queue has room
        WR_BLOCKED = 2'd2    // data buffered but the queue is full
    } writer_state_e;

    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/queue_writer_skid.sv
// Two-entry FIFO skid buffer between the upstream valid/ready stream and the queue.
// Ports:
//  clk, nrst   clock, asynchronous active-low reset
//  i_valid     upstream word valid
//  o_ready     upstream may transfer (fewer than 2 words held); driven from the count flop only
//  i_data      upstream word
//  i_pop       remove the head word (ignored while empty)
//  o_push      a word is being accepted this cycle
//  o_head      head word, 0 when empty
//  o_count     number of words held (0..2)
// Handshake: a word transfers on a rising edge where i_valid && o_ready.
module queue_writer_skid
    import queue_pkg::*;
#(
    parameter int DW = Q_DW
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [DW-1:0] i_data,
    input  logic          i_pop,
    output logic          o_push,
    output logic [DW-1:0] o_head,
    output logic [1:0]    o_count
);

    logic [DW-1:0] r_mem [2];
    logic          r_wr_ptr;
    logic          r_rd_ptr;
    logic [1:0]    r_count;

    logic          w_push;
    logic          w_pop;

    // Ready looks only at the stored count, so there is no path from i_valid.
    assign o_ready = (r_count != 2'd2);
    assign w_push  = i_valid && o_ready;
    assign w_pop   = i_pop && (r_count != 2'd0);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_push  = w_push;
    assign o_head  = (r_count != 2'd0) ? r_mem[r_rd_ptr] : '0;
    assign o_count = r_count;

endmodule

// File: rtl/queue_writer.sv
// Producer-side controller for a 4-entry nibble queue that has no full/empty flags.
// Buffers upstream words in a 2-entry skid buffer, drives the queue enq/din, arbitrates
// queue access against the consumer's deq request, and tracks occupancy with a credit counter.
// Ports:
//  clk, nrst          clock, asynchronous active-low reset
//  s_valid/s_ready    upstream handshake; a word transfers on a rising edge with both high
//  s_data             upstream word
//  deq_req            consumer wants to dequeue this cycle
//  deq_grant          consumer dequeue honoured this cycle (drives the queue deq)
//  enq, din           queue enqueue strobe and write data (din = buffer head, 0 when empty)
//  occupancy          words currently in the queue
//  full, empty        occupancy == DEPTH / occupancy == 0
//  dbg_state          writer FSM state for observation
// Configuration: define QUEUE_WRITER_FAIR_EN to guarantee the writer one slot every
// MAX_YIELD+1 cycles under a continuous deq_req; otherwise the consumer always wins.
module queue_writer
    import queue_pkg::*;
#(
    parameter int DW    = Q_DW,
    parameter int DEPTH = Q_DEPTH
`ifdef QUEUE_WRITER_FAIR_EN
    ,
    parameter int MAX_YIELD = Q_MAX_YIELD
`endif
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [DW-1:0]             s_data,
    input  logic                      deq_req,
    output logic                      deq_grant,
    output logic                      enq,
    output logic [DW-1:0]             din,
    output logic [occ_w(DEPTH)-1:0]   occupancy,
    output logic                      full,
    output logic                      empty,
    output writer_state_e             dbg_state
);

    localparam int             OW      = occ_w(DEPTH);
    localparam logic [OW-1:0]  OCC_MAX = OW'(DEPTH);
    localparam logic [OW-1:0]  OCC_ONE = OW'(1);

    logic [OW-1:0]  r_occ;
    logic [OW-1:0]  w_occ_next;
    writer_state_e  r_state;
    writer_state_e  w_state_next;

    logic           w_push;
    logic [1:0]     w_count;
    logic [1:0]     w_count_next;
    logic           w_nonempty;
    logic           w_has_credit;
    logic           w_force_wr;
    logic           w_deq_grant;
    logic           w_enq;

    queue_writer_skid #(.DW(DW)) u_skid (
        .clk     (clk),
        .nrst    (nrst),
        .i_valid (s_valid),
        .o_ready (s_ready),
        .i_data  (s_data),
        .i_pop   (w_enq),
        .o_push  (w_push),
        .o_head  (din),
        .o_count (w_count)
    );

    assign w_nonempty   = (w_count != 2'd0);
    assign w_has_credit = (r_occ < OCC_MAX);

`ifdef QUEUE_WRITER_FAIR_EN
    localparam int YW = $clog2(MAX_YIELD + 1);
    localparam logic [YW-1:0] YIELD_MAX = YW'(MAX_YIELD);

    logic [YW-1:0] r_yield;

    // Force only when the writer can actually use the slot, so the consumer is
    // never locked out by a writer that has nothing to write.
    assign w_force_wr = (r_yield == YIELD_MAX) && w_nonempty && w_has_credit;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_yield <= '0;
        end else if (w_enq) begin
            r_yield <= '0;
        end else if (w_nonempty && w_has_credit && w_deq_grant) begin
            r_yield <= r_yield + YW'(1);
        end
    end
`else
    assign w_force_wr = 1'b0;
`endif

    // Consumer has priority unless the writer is owed a forced slot; enq and
    // deq_grant are mutually exclusive by construction.
    assign w_deq_grant = deq_req && (r_occ != '0) && !w_force_wr;
    assign w_enq       = w_nonempty && w_has_credit && !w_deq_grant;

    always_comb begin
        w_occ_next = r_occ;
        if (w_enq) begin
            w_occ_next = r_occ + OCC_ONE;
        end else if (w_deq_grant) begin
            w_occ_next = r_occ - OCC_ONE;
        end
    end

    always_comb begin
        w_count_next = w_count;
        case ({w_push, w_enq})
            2'b10:   w_count_next = w_count + 2'd1;
            2'b01:   w_count_next = w_count - 2'd1;
            default: w_count_next = w_count;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_occ <= '0;
        end else begin
            r_occ <= w_occ_next;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= WR_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            WR_IDLE: begin
                if (w_count_next != 2'd0) begin
                    w_state_next = (w_occ_next == OCC_MAX) ? WR_BLOCKED : WR_ACTIVE;
                end
            end
            WR_ACTIVE: begin
                if (w_count_next == 2'd0) begin
                    w_state_next = WR_IDLE;
                end else if (w_occ_next == OCC_MAX) begin
                    w_state_next = WR_BLOCKED;
                end
            end
            WR_BLOCKED: begin
                if (w_count_next == 2'd0) begin
                    w_state_next = WR_IDLE;
                end else if (w_deq_grant) begin
                    w_state_next = WR_ACTIVE;
                end
            end
            default: w_state_next = WR_IDLE;
        endcase
    end

    assign deq_grant = w_deq_grant;
    assign enq       = w_enq;
    assign occupancy = r_occ;
    assign full      = (r_occ == OCC_MAX);
    assign empty     = (r_occ == '0);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_queue_writer.sv
// Bench for queue_writer. The reference model keeps the skid buffer and the queue as plain
// queues and applies the arbitration rules directly each cycle. A monitor process models the
// physical queue from the DUT's own enq/deq_grant and checks ordering, overflow and underflow.
module tb_queue_writer;
    import queue_pkg::*;

    localparam int DEPTH     = 4;
    localparam int MAX_YIELD = 4;

    logic          clk = 1'b0;
    logic          nrst;
    logic          s_valid;
    logic          s_ready;
    logic [3:0]    s_data;
    logic          deq_req;
    logic          deq_grant;
    logic          enq;
    logic [3:0]    din;
    logic [2:0]    occupancy;
    logic          full;
    logic          empty;
    writer_state_e dbg_state;

    int n_vec = 0;
    int n_err = 0;

    logic [3:0] exp_q[$];      // expected din on each enq strobe
    logic [3:0] exp_deq_q[$];  // accepted words, in the order the consumer must see them
    logic [3:0] sk_q[$];       // model skid buffer
    logic [3:0] mq_q[$];       // model queue contents
    logic [3:0] phys_q[$];     // queue rebuilt from DUT strobes
    int         ycnt = 0;

    queue_writer dut (
        .clk       (clk),
        .nrst      (nrst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .deq_req   (deq_req),
        .deq_grant (deq_grant),
        .enq       (enq),
        .din       (din),
        .occupancy (occupancy),
        .full      (full),
        .empty     (empty),
        .dbg_state (dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus plus model evaluation.
    task automatic step(input logic v, input logic [3:0] d, input logic dq);
        logic       e_force;
        logic       e_grant;
        logic       e_enq;
        logic       e_ready;
        logic [3:0] e_din;
        int         occ;
        int         e_state;
        @(negedge clk);
        s_valid = v;
        s_data  = d;
        deq_req = dq;
        #1;
        occ     = mq_q.size();
        e_ready = (sk_q.size() < 2);
        e_din   = (sk_q.size() > 0) ? sk_q[0] : 4'd0;
`ifdef QUEUE_WRITER_FAIR_EN
        e_force = (ycnt == MAX_YIELD) && (sk_q.size() > 0) && (occ < DEPTH);
`else
        e_force = 1'b0;
`endif
        e_grant = dq && (occ != 0) && !e_force;
        e_enq   = (sk_q.size() > 0) && (occ < DEPTH) && !e_grant;
        if (sk_q.size() == 0)      e_state = int'(WR_IDLE);
        else if (occ == DEPTH)     e_state = int'(WR_BLOCKED);
        else                       e_state = int'(WR_ACTIVE);

        check("s_ready",   s_ready,   e_ready);
        check("deq_grant", deq_grant, e_grant);
        check("enq",       enq,       e_enq);
        check("din",       din,       e_din);
        check("occupancy", occupancy, occ);
        check("full",      full,      occ == DEPTH);
        check("empty",     empty,     occ == 0);
        check("state",     int'(dbg_state), e_state);

        if (e_enq) exp_q.push_back(sk_q[0]);
`ifdef QUEUE_WRITER_FAIR_EN
        if (e_enq) ycnt = 0;
        else if ((sk_q.size() > 0) && (occ < DEPTH) && e_grant) ycnt++;
`endif
        if (e_grant) void'(mq_q.pop_front());
        if (e_enq)   mq_q.push_back(sk_q.pop_front());
        if (v && e_ready) begin
            sk_q.push_back(d);
            exp_deq_q.push_back(d);
        end
    endtask

    // Hold reset for some cycles with random inputs; ends released at a falling edge.
    task automatic do_reset(input int cycles);
        @(negedge clk);
        nrst = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            s_valid = 1'($urandom);
            s_data  = 4'($urandom);
            deq_req = 1'($urandom);
            #1;
            check("rst_enq",       enq,       0);
            check("rst_deq_grant", deq_grant, 0);
            check("rst_occupancy", occupancy, 0);
            check("rst_empty",     empty,     1);
            check("rst_full",      full,      0);
            check("rst_s_ready",   s_ready,   1);
            check("rst_din",       din,       0);
            @(negedge clk);
        end
        sk_q.delete();
        mq_q.delete();
        exp_q.delete();
        exp_deq_q.delete();
        ycnt    = 0;
        s_valid = 1'b0;
        deq_req = 1'b0;
        s_data  = 4'd0;
        nrst    = 1'b1;
    endtask

    // monitor: rebuilds the queue from the DUT strobes and checks data order
    initial begin
        logic [3:0] got;
        forever begin
            @(negedge clk);
            #2;
            if (!nrst) begin
                phys_q.delete();
            end else begin
                if (enq && deq_grant) check("enq_with_grant", 1, 0);
                if (deq_grant) begin
                    if (phys_q.size() == 0) begin
                        check("underflow_grant", deq_grant, 0);
                    end else begin
                        got = phys_q.pop_front();
                        if (exp_deq_q.size() == 0) check("deq_unexpected", 1, 0);
                        else check("deq_data", got, exp_deq_q.pop_front());
                    end
                end
                if (enq) begin
                    if (phys_q.size() >= DEPTH) check("overflow_enq", enq, 0);
                    else phys_q.push_back(din);
                    if (exp_q.size() == 0) check("enq_unexpected", 1, 0);
                    else check("enq_din", din, exp_q.pop_front());
                end
            end
        end
    end

    // driver
    initial begin
        nrst    = 1'b0;
        s_valid = 1'b0;
        s_data  = 4'd0;
        deq_req = 1'b0;

        do_reset(3);

        // Burst 1..5 into an idle queue, then one more word fills the buffer.
        for (int i = 1; i <= 5; i++) step(1'b1, 4'(i), 1'b0);
        step(1'b0, 4'd0, 1'b0);
        step(1'b1, 4'd6, 1'b0);
        step(1'b0, 4'd0, 1'b0);
        // Single deq pulse from full, then the writer refills.
        step(1'b0, 4'd0, 1'b1);
        step(1'b0, 4'd0, 1'b0);
        step(1'b0, 4'd0, 1'b0);

        // Occupancy 2 with a buffered word and a deq request in the same cycle.
        do_reset(1);
        step(1'b1, 4'd7, 1'b0);
        step(1'b1, 4'd8, 1'b0);
        step(1'b1, 4'd9, 1'b0);
        step(1'b0, 4'd0, 1'b1);
        step(1'b0, 4'd0, 1'b0);

        // Continuous deq_req with continuous upstream data.
        for (int i = 0; i < 40; i++) step(1'b1, 4'($urandom), 1'b1);

        // Reset mid-burst with three words in the queue, then quiet cycles.
        do_reset(1);
        for (int i = 0; i < 4; i++) step(1'b1, 4'(10 + i), 1'b0);
        do_reset(2);
        for (int i = 0; i < 4; i++) step(1'b0, 4'd0, 1'b0);
        step(1'b1, 4'd3, 1'b0);
        step(1'b0, 4'd0, 1'b0);

        // Random traffic at several valid/deq densities.
        for (int seg = 0; seg < 4; seg++) begin
            int pv;
            int pd;
            pv = $urandom_range(20, 95);
            pd = $urandom_range(20, 95);
            for (int i = 0; i < 100; i++) begin
                step($urandom_range(0, 99) < pv, 4'($urandom), $urandom_range(0, 99) < pd);
            end
        end

        // Drain.
        for (int i = 0; i < 10; i++) step(1'b0, 4'd0, 1'b1);

        @(negedge clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
